// File: rtl/wb_region_decoder_if.sv
// rtl/wb_region_decoder_if.sv - Wishbone slave-window bus between the Caravel master and the region decoder
interface wb_region_decoder_if #(
    parameter int ADDR_W = 32
) ();
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [ADDR_W-1:0] wbs_adr_i;
    logic              wbs_ack_o;
    logic              wbs_err_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i,
        input  wbs_ack_o, wbs_err_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i,
        output wbs_ack_o, wbs_err_o
    );
endinterface

// File: rtl/wb_region_decoder.sv
// rtl/wb_region_decoder.sv - registered Wishbone region decoder for the neuron core window
// Optional WAIT timeout is built when ADDR_DEC_TIMEOUT_EN is defined.
module wb_region_decoder #(
    parameter int                  ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR   = 32'h3000_0000,
    parameter int                  SEL_HI      = 15,
    parameter int                  SEL_W       = 2,
    parameter int                  IDX_W       = 8,
    parameter logic [5*(2**SEL_W)-1:0] IDX_LSB_VEC = {5'd0, 5'd0, 5'd4, 5'd0},
    parameter int                  TIMEOUT_CYC = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    wb_region_decoder_if.slave    wbs,
    input  logic [2**SEL_W-1:0]   region_en_i,
    input  logic [2**SEL_W-1:0]   slv_ack_i,
    output logic [2**SEL_W-1:0]   sel_o,
    output logic [SEL_W-1:0]      region_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  we_o,
    output logic                  req_o,
    output logic                  busy_o
);

    localparam int NUM_REG = 2**SEL_W;
    localparam int TAG_LSB = SEL_HI + 1;

    if (SEL_HI >= ADDR_W - 1 || SEL_HI + 1 < SEL_W || IDX_W < 1 || TIMEOUT_CYC < 1) begin : g_cfg_err
        $error("wb_region_decoder: inconsistent parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] adr_q;
    logic              we_q;

    logic [SEL_W-1:0]        dec_region;
    logic                    dec_base_hit;
    logic                    dec_hit;
    logic [4:0]              dec_lsb;
    logic [ADDR_W+IDX_W-1:0] adr_ext;
    logic [IDX_W-1:0]        dec_idx;
    logic [NUM_REG-1:0]      dec_onehot;
    logic                    slv_ack_sel;
    logic                    timeout_hit;

    // Decode works on the latched address so the master may change adr after acceptance.
    assign dec_region   = adr_q[SEL_HI -: SEL_W];
    assign dec_base_hit = (adr_q[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]);
    assign dec_hit      = dec_base_hit & region_en_i[dec_region];
    assign dec_lsb      = IDX_LSB_VEC[dec_region*5 +: 5];
    // Zero padding above the MSB makes index bits beyond the address read as 0.
    assign adr_ext      = {{IDX_W{1'b0}}, adr_q};
    assign dec_idx      = IDX_W'(adr_ext >> dec_lsb);
    assign dec_onehot   = NUM_REG'(1) << dec_region;
    assign slv_ack_sel  = slv_ack_i[region_o];

`ifdef ADDR_DEC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wait_cnt <= '0;
        end else if (state != S_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state         <= S_IDLE;
            adr_q         <= '0;
            we_q          <= 1'b0;
            sel_o         <= '0;
            region_o      <= '0;
            idx_o         <= '0;
            we_o          <= 1'b0;
            req_o         <= 1'b0;
            busy_o        <= 1'b0;
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_err_o <= 1'b0;
        end else begin
            req_o         <= 1'b0;
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
                        adr_q  <= wbs.wbs_adr_i;
                        we_q   <= wbs.wbs_we_i;
                        busy_o <= 1'b1;
                        state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!wbs.wbs_cyc_i) begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end else if (dec_hit) begin
                        sel_o    <= dec_onehot;
                        region_o <= dec_region;
                        idx_o    <= dec_idx;
                        we_o     <= we_q;
                        req_o    <= 1'b1;
                        state    <= S_WAIT;
                    end else begin
                        wbs.wbs_err_o <= 1'b1;
                        state         <= S_RESP;
                    end
                end
                S_WAIT: begin
                    // Abort outranks a same-cycle slave ack, and ack outranks timeout.
                    if (!wbs.wbs_cyc_i) begin
                        sel_o  <= '0;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end else if (slv_ack_sel) begin
                        sel_o         <= '0;
                        wbs.wbs_ack_o <= 1'b1;
                        state         <= S_RESP;
                    end else if (timeout_hit) begin
                        sel_o         <= '0;
                        wbs.wbs_err_o <= 1'b1;
                        state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    sel_o  <= '0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
